// File: rtl/doraemon_pkg.sv
// Shared definitions for the doraemon selection engine.
// Holds the engine FSM state type, the default parameter values and the
// helper functions that derive the door-index width and the score width.
package doraemon_pkg;

    localparam int NUM_DOOR_DEF = 5;
    localparam int DW_DEF       = 8;
    localparam int WW_DEF       = 3;
    localparam int IDW_DEF      = 5;
    localparam int FDEPTH_DEF   = 8;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_IDLE,
        ST_CALC,
        ST_SEL,
        ST_OUT
    } state_t;

    // Bits needed to index num_door door slots.
    function automatic int door_w(input int num_door);
        return $clog2(num_door);
    endfunction

    // Each product needs dw+ww bits; summing three of them adds two more.
    function automatic int score_w(input int dw, input int ww);
        return dw + ww + 2;
    endfunction

endpackage

// File: rtl/doraemon_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used as the engine input queue.
// Ports:
//   clk, rst        clock and asynchronous active-high reset (pointers only)
//   i_clear         synchronous flush, overrides push and pop
//   i_push, i_data  write request and data (ignored when full)
//   i_pop           read request (ignored when empty)
//   o_data          head entry, valid whenever o_empty is low
//   o_full, o_empty occupancy flags
//   o_count         current number of stored entries
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/doraemon_sel_engine.sv
// Doraemon selection engine.
// The first NUM_DOOR queued items fill the door slots. Every later item is
// scored against all doors with its own weights; the best-scoring door
// (lowest index on ties) is reported as {door index, door id} and then
// replaced by the item.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   clear                    synchronous restart (flush queue, refill doors)
//   in_valid / in_ready      item handshake
//   doraemon_id, size, iq_score, eq_score   item fields
//   size_weight, iq_weight, eq_weight       weights travelling with the item
//   out_valid / out_ready    result handshake, result held until accepted
//   out                      {door index, selected door id}
module doraemon_sel_engine
    import doraemon_pkg::*;
#(
    parameter  int NUM_DOOR = NUM_DOOR_DEF,
    parameter  int DW       = DW_DEF,
    parameter  int WW       = WW_DEF,
    parameter  int IDW      = IDW_DEF,
    parameter  int FDEPTH   = FDEPTH_DEF,
    localparam int DOORW    = door_w(NUM_DOOR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IDW-1:0]       doraemon_id,
    input  logic [DW-1:0]        size,
    input  logic [DW-1:0]        iq_score,
    input  logic [DW-1:0]        eq_score,
    input  logic [WW-1:0]        size_weight,
    input  logic [WW-1:0]        iq_weight,
    input  logic [WW-1:0]        eq_weight,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DOORW+IDW-1:0] out
);

    localparam int SW = score_w(DW, WW);
    localparam int FW = IDW + 3 * DW + 3 * WW;
    localparam int CW = $clog2(FDEPTH) + 1;

    function automatic logic [SW-1:0] calc_score(
        input logic [DW-1:0] s, input logic [DW-1:0] q, input logic [DW-1:0] e,
        input logic [WW-1:0] a, input logic [WW-1:0] b, input logic [WW-1:0] c
    );
        return SW'(s) * SW'(a) + SW'(q) * SW'(b) + SW'(e) * SW'(c);
    endfunction

    // Queue signals and the unpacked head entry.
    logic [FW-1:0]  w_fifo_wdata;
    logic [FW-1:0]  w_fifo_rdata;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_out_hs;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_count_next;
    logic [IDW-1:0] w_id_p0;
    logic [DW-1:0]  w_size_p0;
    logic [DW-1:0]  w_iq_p0;
    logic [DW-1:0]  w_eq_p0;
    logic [WW-1:0]  w_sw_p0;
    logic [WW-1:0]  w_iw_p0;
    logic [WW-1:0]  w_ew_p0;

    // Control state.
    state_t               r_state;
    logic [DOORW-1:0]     r_fill_cnt;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [DOORW+IDW-1:0] r_out;

    // Door slots, held item and pipeline data (no reset needed).
    logic [IDW-1:0]   r_door_id   [NUM_DOOR];
    logic [DW-1:0]    r_door_size [NUM_DOOR];
    logic [DW-1:0]    r_door_iq   [NUM_DOOR];
    logic [DW-1:0]    r_door_eq   [NUM_DOOR];
    logic [IDW-1:0]   r_hold_id_p0;
    logic [DW-1:0]    r_hold_size_p0;
    logic [DW-1:0]    r_hold_iq_p0;
    logic [DW-1:0]    r_hold_eq_p0;
    logic [WW-1:0]    r_hold_sw_p0;
    logic [WW-1:0]    r_hold_iw_p0;
    logic [WW-1:0]    r_hold_ew_p0;
    logic [SW-1:0]    r_score_p1  [NUM_DOOR];
    logic [DOORW-1:0] r_sel_p2;
    logic [DOORW-1:0] w_best_idx;
    logic [SW-1:0]    w_best_score;

    assign w_fifo_wdata = {doraemon_id, size, iq_score, eq_score,
                           size_weight, iq_weight, eq_weight};
    assign {w_id_p0, w_size_p0, w_iq_p0, w_eq_p0,
            w_sw_p0, w_iw_p0, w_ew_p0} = w_fifo_rdata;

    // clear discards any item offered in the same cycle.
    assign w_push   = in_valid && r_in_ready && !clear;
    assign w_pop    = !clear && !w_empty && (r_state == ST_FILL || r_state == ST_IDLE);
    assign w_out_hs = r_out_valid && out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear),
        .i_push  (w_push),
        .i_data  (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Next occupancy lets in_ready be a flop that still tracks "not full"
    // in the same cycle the FIFO reaches or leaves the full state.
    always_comb begin
        w_count_next = w_count;
        if (w_push && !w_full) w_count_next = w_count_next + CW'(1);
        if (w_pop)             w_count_next = w_count_next - CW'(1);
    end

    // Argmax over registered scores; strict compare keeps the lowest index on ties.
    always_comb begin
        w_best_idx   = '0;
        w_best_score = r_score_p1[0];
        for (int d = 1; d < NUM_DOOR; d++) begin
            if (r_score_p1[d] > w_best_score) begin
                w_best_score = r_score_p1[d];
                w_best_idx   = DOORW'(d);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_fill_cnt  <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            r_in_ready <= clear ? 1'b1 : (w_count_next != CW'(FDEPTH));
            if (clear) begin
                r_state     <= ST_FILL;
                r_fill_cnt  <= '0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_FILL: begin
                        if (w_pop) begin
                            if (r_fill_cnt == DOORW'(NUM_DOOR - 1)) begin
                                r_fill_cnt <= '0;
                                r_state    <= ST_IDLE;
                            end else begin
                                r_fill_cnt <= r_fill_cnt + DOORW'(1);
                            end
                        end
                    end
                    ST_IDLE: if (w_pop) r_state <= ST_CALC;
                    ST_CALC: r_state <= ST_SEL;
                    ST_SEL: begin
                        r_out_valid <= 1'b1;
                        r_out       <= {w_best_idx, r_door_id[w_best_idx]};
                        r_state     <= ST_OUT;
                    end
                    ST_OUT: begin
                        if (w_out_hs) begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        // p0: door fill / item hold
        if (r_state == ST_FILL && w_pop) begin
            r_door_id[r_fill_cnt]   <= w_id_p0;
            r_door_size[r_fill_cnt] <= w_size_p0;
            r_door_iq[r_fill_cnt]   <= w_iq_p0;
            r_door_eq[r_fill_cnt]   <= w_eq_p0;
        end
        if (r_state == ST_IDLE && w_pop) begin
            r_hold_id_p0   <= w_id_p0;
            r_hold_size_p0 <= w_size_p0;
            r_hold_iq_p0   <= w_iq_p0;
            r_hold_eq_p0   <= w_eq_p0;
            r_hold_sw_p0   <= w_sw_p0;
            r_hold_iw_p0   <= w_iw_p0;
            r_hold_ew_p0   <= w_ew_p0;
        end
        // p1: per-door scores
        if (r_state == ST_CALC) begin
            for (int d = 0; d < NUM_DOOR; d++) begin
                r_score_p1[d] <= calc_score(r_door_size[d], r_door_iq[d], r_door_eq[d],
                                            r_hold_sw_p0, r_hold_iw_p0, r_hold_ew_p0);
            end
        end
        // p2: selected door, replaced by the held item once the result is taken
        if (r_state == ST_SEL) r_sel_p2 <= w_best_idx;
        if (r_state == ST_OUT && w_out_hs && !clear) begin
            r_door_id[r_sel_p2]   <= r_hold_id_p0;
            r_door_size[r_sel_p2] <= r_hold_size_p0;
            r_door_iq[r_sel_p2]   <= r_hold_iq_p0;
            r_door_eq[r_sel_p2]   <= r_hold_eq_p0;
        end
    end

endmodule

// File: tb/tb_doraemon_sel_engine.sv
module tb_doraemon_sel_engine;

    localparam int ND    = 5;
    localparam int DW    = 8;
    localparam int WW    = 3;
    localparam int IDW   = 5;
    localparam int FD    = 8;
    localparam int DOORW = $clog2(ND);
    localparam int OW    = DOORW + IDW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clear = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [IDW-1:0] id = '0;
    logic [DW-1:0]  sz = '0, iq = '0, eq = '0;
    logic [WW-1:0]  sw = '0, iw = '0, ew = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [OW-1:0]  out;

    // Second build with eight doors for the wide tie case.
    logic           b_clear = 1'b0;
    logic           b_in_valid = 1'b0;
    logic           b_in_ready;
    logic [4:0]     b_id = '0;
    logic [7:0]     b_sz = '0, b_iq = '0, b_eq = '0;
    logic [2:0]     b_sw = '0, b_iw = '0, b_ew = '0;
    logic           b_out_valid;
    logic           b_out_ready = 1'b1;
    logic [7:0]     b_out;

    always #5 clk = ~clk;

    doraemon_sel_engine #(.NUM_DOOR(ND), .DW(DW), .WW(WW), .IDW(IDW), .FDEPTH(FD)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .doraemon_id(id), .size(sz), .iq_score(iq), .eq_score(eq),
        .size_weight(sw), .iq_weight(iw), .eq_weight(ew),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    doraemon_sel_engine #(.NUM_DOOR(8), .DW(8), .WW(3), .IDW(5), .FDEPTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .doraemon_id(b_id), .size(b_sz), .iq_score(b_iq), .eq_score(b_eq),
        .size_weight(b_sw), .iq_weight(b_iw), .eq_weight(b_ew),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
    );

    int total = 0;
    int bad   = 0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    // Reference model: door contents as plain arrays, results in arrival order.
    int            m_fill = 0;
    int            m_id [ND];
    int            m_sz [ND];
    int            m_iq [ND];
    int            m_eq [ND];
    logic [OW-1:0] expq [$];
    bit            hold_chk = 0;
    logic [OW-1:0] last_out = '0;
    bit            rnd_ready = 0;

    function automatic void model_accept(int i_id, int s, int q, int e, int a, int b, int c);
        int best;
        int bs;
        int sc;
        if (m_fill < ND) begin
            m_id[m_fill] = i_id; m_sz[m_fill] = s; m_iq[m_fill] = q; m_eq[m_fill] = e;
            m_fill++;
        end else begin
            best = 0;
            bs   = m_sz[0] * a + m_iq[0] * b + m_eq[0] * c;
            for (int d = 1; d < ND; d++) begin
                sc = m_sz[d] * a + m_iq[d] * b + m_eq[d] * c;
                if (sc > bs) begin
                    bs   = sc;
                    best = d;
                end
            end
            expq.push_back(OW'(best * (1 << IDW) + m_id[best]));
            m_id[best] = i_id; m_sz[best] = s; m_iq[best] = q; m_eq[best] = e;
        end
    endfunction

    // Monitor: everything sampled here is stable until the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_chk = 0;
        end else if (clear) begin
            m_fill = 0;
            expq.delete();
            hold_chk = 0;
        end else begin
            if (hold_chk) begin
                check("valid_held", out_valid, 1);
                check("out_stable", out, last_out);
            end
            if (out_valid && expq.size() == 0)
                check("spurious_out", out_valid, 0);
            else if (out_valid && out_ready)
                check("out_result", out, expq.pop_front());
            hold_chk = out_valid && !out_ready;
            last_out = out;
            if (in_valid && in_ready)
                model_accept(int'(id), int'(sz), int'(iq), int'(eq), int'(sw), int'(iw), int'(ew));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int i_id, input int s, input int q, input int e,
                        input int a, input int b, input int c);
        bit done;
        done = 0;
        in_valid = 1'b1;
        id = IDW'(i_id); sz = DW'(s); iq = DW'(q); eq = DW'(e);
        sw = WW'(a); iw = WW'(b); ew = WW'(c);
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", in_ready, 1);
    endtask

    task automatic send8(input int i_id, input int s, input int a);
        bit done;
        done = 0;
        b_in_valid = 1'b1;
        b_id = 5'(i_id); b_sz = 8'(s); b_iq = 8'($urandom_range(0, 255)); b_eq = 8'($urandom_range(0, 255));
        b_sw = 3'(a); b_iw = 3'd0; b_ew = 3'd0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = b_in_ready;
            tick();
        end
        b_in_valid = 1'b0;
        if (!done) check("send8_timeout", b_in_ready, 1);
    endtask

    task automatic wait_out();
        for (int k = 0; k < 200 && !out_valid; k++) tick();
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && (expq.size() != 0 || out_valid); k++) tick();
        check("drain_done", expq.size(), 0);
        repeat (12) tick();
    endtask

    function automatic int rnd_field();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 0;
        if (r == 1) return 255;
        return int'($urandom_range(0, 255));
    endfunction

    task automatic send_rnd();
        send(int'($urandom_range(0, 31)), rnd_field(), rnd_field(), rnd_field(),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        // Reset state
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        check("in_ready_before_edge", in_ready, 0);
        tick();
        check("in_ready_after_edge", in_ready, 1);

        // Eight doors: tie between doors 2 and 7 resolves to door 2
        for (int d = 0; d < 8; d++) send8(d + 1, (d == 2 || d == 7) ? 100 : 5, 5);
        send8(9, 0, 1);
        for (int k = 0; k < 200 && !b_out_valid; k++) tick();
        check("nd8_tie_out", b_out, 8'h43);
        tick();

        // Directed selection with lowest-index tie
        out_ready = 1'b1;
        send(1, 10, 77, 12, 5, 5, 5);
        send(2, 50, 3, 200, 1, 2, 3);
        send(3, 30, 99, 0, 7, 7, 7);
        send(4, 50, 1, 1, 0, 0, 0);
        send(5, 20, 255, 255, 4, 4, 4);
        send(6, 0, 200, 200, 1, 0, 0);
        wait_out();
        check("tie_lowest_door", out, 8'h22);
        send(7, 0, 100, 100, 1, 0, 0);
        wait_out();
        check("second_select", out, 8'h64);
        drain();

        // Back-pressure: result held while the queue fills
        out_ready = 1'b0;
        send_rnd();
        wait_out();
        acc = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            id = IDW'($urandom_range(0, 31)); sz = DW'(rnd_field()); iq = DW'(rnd_field());
            eq = DW'(rnd_field()); sw = WW'($urandom_range(0, 7)); iw = WW'($urandom_range(0, 7));
            ew = WW'($urandom_range(0, 7));
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("fifo_push_count", acc, 8);
        check("in_ready_full", in_ready, 0);
        out_ready = 1'b1;
        drain();
        repeat (4) send_rnd();
        drain();

        // clear while a result is pending, item offered in the clear cycle dropped
        out_ready = 1'b0;
        send_rnd();
        wait_out();
        clear = 1'b1;
        in_valid = 1'b1;
        id = 5'd30; sz = 8'd255; sw = 3'd7;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clear_out_valid", out_valid, 0);
        check("clear_in_ready", in_ready, 1);
        out_ready = 1'b1;
        send(11, 255, 255, 255, 0, 0, 0);
        for (int d = 1; d < ND; d++)
            send(d + 12, int'($urandom_range(0, 200)), int'($urandom_range(0, 200)),
                 int'($urandom_range(0, 200)), 7, 7, 7);
        repeat (8) tick();
        check("refill_no_out", out_valid, 0);
        send(12, 0, 0, 0, 7, 7, 7);
        wait_out();
        check("max_score_door0", out, 8'h0B);
        drain();

        // Randomized traffic with random back-pressure
        rnd_ready = 1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_rnd();
        end
        drain();
        rnd_ready = 0;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset in the scoring cycle
        send_rnd();
        tick();
        #2;
        rst = 1'b1;
        m_fill = 0;
        expq.delete();
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out", out, 0);
        check("arst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        check("arst_in_ready_low", in_ready, 0);
        tick();
        check("arst_in_ready_high", in_ready, 1);
        repeat (7) send_rnd();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/doraemon_sel_engine.md
DORAEMON_SEL_ENGINE -- requirements
Module: doraemon_sel_engine

Interface
REQ-001 SHALL have parameter NUM_DOOR, default 5, number of door slots (legal 2..8).
REQ-002 SHALL have parameter DW, default 8, width of size, iq_score and eq_score.
REQ-003 SHALL have parameter WW, default 3, width of each weight.
REQ-004 SHALL have parameter IDW, default 5, width of doraemon_id.
REQ-005 SHALL have parameter FDEPTH, default 8, input FIFO depth (power of 2, >=2).
REQ-006 SHALL use one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-007 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-008 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-009 SHALL have port clear  in  1  synchronous restart: flush FIFO, empty doors, drop pending result.
REQ-010 SHALL have port in_valid  in  1  item offered this cycle.
REQ-011 SHALL have port in_ready  out  1  item accepted when in_valid && in_ready.
REQ-012 SHALL have ports doraemon_id (IDW), size, iq_score, eq_score (DW each)  in  item fields.
REQ-013 SHALL have ports size_weight, iq_weight, eq_weight  in  WW each  weights travelling with the item.
REQ-014 SHALL have port out_valid  out  1  result held until out_ready.
REQ-015 SHALL have port out_ready  in  1  consumer accepts result.
REQ-016 SHALL have port out  out  DOORW+IDW  {door index (MSBs, DOORW = clog2(NUM_DOOR)), selected id (LSBs)}.

Function
REQ-017 SHALL push every accepted item, with its weights, into an internal FIFO of FDEPTH entries.
REQ-018 SHALL drive in_ready = FIFO not full, registered; no push occurs when full, even with a same-cycle pop.
REQ-019 SHALL run the FSM FILL -> IDLE -> CALC -> SEL -> OUT -> IDLE.
REQ-020 FILL: pop one item per cycle when FIFO is non-empty and write it to door[fill_cnt]; weights are ignored and no output is produced; after NUM_DOOR pops go to IDLE.
REQ-021 IDLE: when FIFO is non-empty, pop one item into a hold register and go to CALC.
REQ-022 CALC: register score[d] = size*size_weight + iq*iq_weight + eq*eq_weight for every door, with the held item's weights, unsigned, DW+WW+2 bits, no truncation.
REQ-023 SEL: register the argmax door; ties resolve to the lowest index.
REQ-024 OUT: assert out_valid with out = {door index, door id}; hold both stable until out_ready.
REQ-025 SHALL, on the out handshake, overwrite the selected door with the held item and return to IDLE.
REQ-026 Latency SHALL be 3 cycles from pop in IDLE to out_valid, minimum 4 cycles between results.
REQ-027 out_ready SHALL have no effect while out_valid is 0.
REQ-028 clear SHALL take priority over every other event: next cycle FILL, fill_cnt 0, FIFO empty, out_valid 0, in_ready 1; an item offered in the clear cycle is discarded.
REQ-029 Door contents SHALL persist indefinitely; NUM_DOOR = 1 is not supported.

Reset
REQ-030 rst SHALL asynchronously force FILL, fill_cnt 0, FIFO pointers 0, out_valid 0, out 0, in_ready 0.
REQ-031 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-032 Door and score registers SHALL need no reset; they are never observable before being written.

Structure
REQ-033 Package doraemon_pkg SHALL hold the FSM state enum, the DOORW and score-width functions, and the default parameter constants.
REQ-034 The FIFO SHALL be a separate sub-module, sync_fifo, parametrised on width and depth, with full, empty, push and pop.
REQ-035 Score and argmax logic SHALL stay inside doraemon_sel_engine.

Verification
REQ-036 Fill ids 1..5, sizes 10,50,30,50,20, then id 6 (size 0) with weights (1,0,0) -> out = 8'h22 (door 1, id 2, lowest-index tie); then id 7 with weights (1,0,0) -> out = 8'h64 (door 3, id 4).
REQ-037 Weights (7,7,7) with all fields 255 at door 0 -> score 5355 with no overflow, out door 0.
REQ-038 out_ready held 0 after the first result, 12 items offered -> in_ready falls after 8 pushes; out stays stable; all results are correct after release.
REQ-039 clear pulsed while in OUT -> out_valid 0 next cycle; the next 5 items refill the doors with no output.
REQ-040 rst asserted mid-CALC -> all outputs reset immediately; in_ready is 1 one edge after release.
REQ-041 NUM_DOOR=8, IDW=5 build -> out width 8; a tie across doors 2 and 7 selects door 2.
